// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: NUM_CH GPR write channels, one HI/LO channel and a valid bit.
// Optional performance counters for bubble/hold edges are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int STAGE   = 4,
  parameter int STALL_W = 6,
  parameter int NUM_CH  = 1,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [NUM_CH*ADDR_W-1:0] in_wd,
  input  logic [NUM_CH-1:0]        in_wreg,
  input  logic [NUM_CH*DATA_W-1:0] in_wdata,
  input  logic                     in_whilo,
  input  logic [DATA_W-1:0]        in_hi,
  input  logic [DATA_W-1:0]        in_lo,
  output logic                     out_valid,
  output logic [NUM_CH*ADDR_W-1:0] out_wd,
  output logic [NUM_CH-1:0]        out_wreg,
  output logic [NUM_CH*DATA_W-1:0] out_wdata,
  output logic                     out_whilo,
  output logic [DATA_W-1:0]        out_hi,
  output logic [DATA_W-1:0]        out_lo,
  output logic                     out_hold
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic                     perf_clr,
  output logic [31:0]              perf_bubbles,
  output logic [31:0]              perf_holds
`endif
);

  typedef enum logic [2:0] {
    OP_RESET,
    OP_FLUSH,
    OP_BUBBLE,
    OP_HOLD,
    OP_ADVANCE
  } op_e;

  op_e  op;
  logic downStall;
  logic unusedStall;

  logic                     valid_q, valid_d;
  logic [NUM_CH*ADDR_W-1:0] wd_q, wd_d;
  logic [NUM_CH-1:0]        wreg_q, wreg_d;
  logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;
  logic                     whilo_q, whilo_d;
  logic [DATA_W-1:0]        hi_q, hi_d;
  logic [DATA_W-1:0]        lo_q, lo_d;

  generate
    if (NUM_CH < 1 || NUM_CH > 4) begin : gen_bad_num_ch
      $error("pipe_stage_reg: NUM_CH must be in the range 1..4");
    end
    if (STAGE >= STALL_W) begin : gen_bad_stage
      $error("pipe_stage_reg: STAGE must be less than STALL_W");
    end
    // The last stage has no downstream neighbour, so it can never hold.
    if (STAGE < STALL_W - 1) begin : gen_down_stall
      assign downStall = stall[STAGE+1];
    end else begin : gen_last_stage
      assign downStall = 1'b0;
    end
  endgenerate

  assign unusedStall = ^stall;

  always_comb begin
    op = OP_ADVANCE;
    if (rst) begin
      op = OP_RESET;
    end else if (flush) begin
      op = OP_FLUSH;
    end else if (stall[STAGE]) begin
      op = downStall ? OP_HOLD : OP_BUBBLE;
    end
  end

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (op)
      OP_RESET, OP_FLUSH, OP_BUBBLE: begin
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = '0;
        wdata_d = '0;
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
      end
      // Enables are qualified by valid; address and data travel unmasked.
      OP_ADVANCE: begin
        valid_d = in_valid;
        wd_d    = in_wd;
        wreg_d  = in_wreg & {NUM_CH{in_valid}};
        wdata_d = in_wdata;
        whilo_d = in_whilo & in_valid;
        hi_d    = in_hi;
        lo_d    = in_lo;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign out_valid = valid_q;
  assign out_wd    = wd_q;
  assign out_wreg  = wreg_q;
  assign out_wdata = wdata_q;
  assign out_whilo = whilo_q;
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;
  assign out_hold  = (op == OP_HOLD);

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_holds_q, perf_holds_d;

  // Saturating counters; a clear request beats an increment on the same edge.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_holds_d   = perf_holds_q;
    if (perf_clr) begin
      perf_bubbles_d = '0;
      perf_holds_d   = '0;
    end else begin
      if ((op == OP_BUBBLE || op == OP_FLUSH) && perf_bubbles_q != 32'hFFFF_FFFF) begin
        perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
      if (op == OP_HOLD && perf_holds_q != 32'hFFFF_FFFF) begin
        perf_holds_d = perf_holds_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_holds_q   <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_holds_q   <= perf_holds_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_holds   = perf_holds_q;
`else
  // Default build carries no performance counters; the stage logic above is complete.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (NUM_CH=2, STAGE=4).
// Perf-counter scenarios are built only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int STAGE   = 4;
  localparam int STALL_W = 6;
  localparam int NUM_CH  = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int OUTW    = 1 + NUM_CH*ADDR_W + NUM_CH + NUM_CH*DATA_W + 1 + 2*DATA_W;

  logic                     clk;
  logic                     rst;
  logic [STALL_W-1:0]       stall;
  logic                     flush;
  logic                     in_valid;
  logic [NUM_CH*ADDR_W-1:0] in_wd;
  logic [NUM_CH-1:0]        in_wreg;
  logic [NUM_CH*DATA_W-1:0] in_wdata;
  logic                     in_whilo;
  logic [DATA_W-1:0]        in_hi;
  logic [DATA_W-1:0]        in_lo;
  logic                     out_valid;
  logic [NUM_CH*ADDR_W-1:0] out_wd;
  logic [NUM_CH-1:0]        out_wreg;
  logic [NUM_CH*DATA_W-1:0] out_wdata;
  logic                     out_whilo;
  logic [DATA_W-1:0]        out_hi;
  logic [DATA_W-1:0]        out_lo;
  logic                     out_hold;
  logic [OUTW-1:0]          allOut;
  logic [OUTW-1:0]          expOut;

  int checks;
  int errors;

  assign allOut = {out_valid, out_wd, out_wreg, out_wdata, out_whilo, out_hi, out_lo};

`ifdef PIPE_STAGE_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_holds;
  logic        p5_clr;
  logic [5:0]  p5_stall;
  logic        p5_valid;
  logic [4:0]  p5_wd;
  logic        p5_wreg;
  logic [31:0] p5_wdata;
  logic        p5_out_valid;
  logic [4:0]  p5_out_wd;
  logic        p5_out_wreg;
  logic [31:0] p5_out_wdata;
  logic        p5_out_whilo;
  logic [31:0] p5_out_hi;
  logic [31:0] p5_out_lo;
  logic        p5_out_hold;
  logic [31:0] p5_bubbles;
  logic [31:0] p5_holds;
`endif

  pipe_stage_reg #(
    .STAGE(STAGE), .STALL_W(STALL_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_whilo(in_whilo), .in_hi(in_hi), .in_lo(in_lo),
    .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .out_whilo(out_whilo), .out_hi(out_hi), .out_lo(out_lo), .out_hold(out_hold)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_clr(perf_clr), .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_reg #(
    .STAGE(5), .STALL_W(6), .NUM_CH(1), .ADDR_W(5), .DATA_W(32)
  ) dut5 (
    .clk(clk), .rst(rst), .stall(p5_stall), .flush(1'b0),
    .in_valid(p5_valid), .in_wd(p5_wd), .in_wreg(p5_wreg), .in_wdata(p5_wdata),
    .in_whilo(1'b0), .in_hi(32'h0), .in_lo(32'h0),
    .out_valid(p5_out_valid), .out_wd(p5_out_wd), .out_wreg(p5_out_wreg),
    .out_wdata(p5_out_wdata), .out_whilo(p5_out_whilo), .out_hi(p5_out_hi),
    .out_lo(p5_out_lo), .out_hold(p5_out_hold),
    .perf_clr(p5_clr), .perf_bubbles(p5_bubbles), .perf_holds(p5_holds)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadVector(input logic v, input logic [9:0] wd, input logic [1:0] wreg,
                            input logic [63:0] wdata, input logic whilo,
                            input logic [31:0] hi, input logic [31:0] lo);
    in_valid = v;
    in_wd    = wd;
    in_wreg  = wreg;
    in_wdata = wdata;
    in_whilo = whilo;
    in_hi    = hi;
    in_lo    = lo;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    flush = 1'b0;
    stall = 6'b110000;
    loadVector(1'b1, 10'h3FF, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h expected 0", allOut);
    end
    checks++;
    if (out_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold got %b expected 0", out_hold);
    end
    rst = 1'b0;
  endtask

  task automatic test_advance();
    stall = 6'b000000;
    loadVector(1'b1, {5'd3, 5'd7}, 2'b11, 64'h1111_2222_DEAD_BEEF, 1'b1, 32'hA, 32'hB);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL advance_latency got valid %b expected 0 before edge", out_valid);
    end
    tick();
    expOut = {1'b1, 5'd3, 5'd7, 2'b11, 64'h1111_2222_DEAD_BEEF, 1'b1, 32'hA, 32'hB};
    checks++;
    if (allOut !== expOut) begin
      errors++;
      $display("[TB] FAIL advance_outputs got %h expected %h", allOut, expOut);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b010000;
    #1;
    checks++;
    if (out_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bubble_hold got %b expected 0", out_hold);
    end
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("[TB] FAIL bubble_outputs got %h expected 0", allOut);
    end
  endtask

  task automatic test_hold();
    stall = 6'b000000;
    loadVector(1'b1, {5'd3, 5'd7}, 2'b11, 64'h1111_2222_DEAD_BEEF, 1'b1, 32'hA, 32'hB);
    tick();
    expOut = {1'b1, 5'd3, 5'd7, 2'b11, 64'h1111_2222_DEAD_BEEF, 1'b1, 32'hA, 32'hB};
    stall = 6'b110000;
    loadVector(1'b1, {5'd9, 5'd1}, 2'b01, 64'h5555_6666_7777_8888, 1'b0, 32'hC, 32'hD);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_hold !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold_flag[%0d] got %b expected 1", i, out_hold);
      end
      tick();
      checks++;
      if (allOut !== expOut) begin
        errors++;
        $display("[TB] FAIL hold_frozen[%0d] got %h expected %h", i, allOut, expOut);
      end
    end
  endtask

  task automatic test_flush();
    stall = 6'b110000;
    flush = 1'b1;
    #1;
    checks++;
    if (out_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_hold got %b expected 0", out_hold);
    end
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("[TB] FAIL flush_outputs got %h expected 0", allOut);
    end
    flush = 1'b0;
  endtask

  task automatic test_invalid_mask();
    stall = 6'b000000;
    loadVector(1'b0, {5'd12, 5'd4}, 2'b11, 64'hCAFE_F00D_0BAD_BEEF, 1'b1, 32'h1234, 32'h5678);
    tick();
    expOut = {1'b0, 5'd12, 5'd4, 2'b00, 64'hCAFE_F00D_0BAD_BEEF, 1'b0, 32'h1234, 32'h5678};
    checks++;
    if (allOut !== expOut) begin
      errors++;
      $display("[TB] FAIL invalid_mask got %h expected %h", allOut, expOut);
    end
  endtask

  task automatic test_back_to_back();
    stall = 6'b000000;
    loadVector(1'b1, {5'd31, 5'd0}, 2'b10, 64'h0000_0001_0000_0002, 1'b0, 32'h1, 32'h2);
    tick();
    expOut = {1'b1, 5'd31, 5'd0, 2'b10, 64'h0000_0001_0000_0002, 1'b0, 32'h1, 32'h2};
    checks++;
    if (allOut !== expOut) begin
      errors++;
      $display("[TB] FAIL b2b_first got %h expected %h", allOut, expOut);
    end
    loadVector(1'b1, {5'd5, 5'd5}, 2'b01, 64'hAAAA_AAAA_5555_5555, 1'b1, 32'hF0, 32'h0F);
    tick();
    expOut = {1'b1, 5'd5, 5'd5, 2'b01, 64'hAAAA_AAAA_5555_5555, 1'b1, 32'hF0, 32'h0F};
    checks++;
    if (allOut !== expOut) begin
      errors++;
      $display("[TB] FAIL b2b_second got %h expected %h", allOut, expOut);
    end
    // Upstream stages stalled but not this one: still advances.
    stall = 6'b001111;
    loadVector(1'b1, {5'd2, 5'd8}, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h77, 32'h88);
    tick();
    expOut = {1'b1, 5'd2, 5'd8, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h77, 32'h88};
    checks++;
    if (allOut !== expOut) begin
      errors++;
      $display("[TB] FAIL b2b_upstream_stall got %h expected %h", allOut, expOut);
    end
  endtask

  task automatic test_reset_mid_hold();
    stall = 6'b110000;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_hold_flag got %b expected 0", out_hold);
    end
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_hold got %h expected 0", allOut);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_hold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_rst_hold_flag got %b expected 1", out_hold);
    end
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("[TB] FAIL post_rst_hold got %h expected 0", allOut);
    end
    stall = 6'b000000;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    p5_clr   = 1'b0;
    p5_valid = 1'b1;
    p5_wd    = 5'd6;
    p5_wreg  = 1'b1;
    p5_wdata = 32'h99;
    p5_stall = 6'b100000;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (p5_bubbles !== 32'd3) begin
      errors++;
      $display("[TB] FAIL perf_bubbles got %0d expected 3", p5_bubbles);
    end
    checks++;
    if (p5_holds !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_holds got %0d expected 0", p5_holds);
    end
    p5_stall = 6'b000000;
    force dut5.perf_bubbles_q = 32'hFFFF_FFFF;
    tick();
    release dut5.perf_bubbles_q;
    p5_stall = 6'b100000;
    tick();
    checks++;
    if (p5_bubbles !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL perf_saturate got %h expected ffffffff", p5_bubbles);
    end
    p5_clr = 1'b1;
    tick();
    p5_clr   = 1'b0;
    p5_stall = 6'b000000;
    checks++;
    if (p5_bubbles !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_clr got %0d expected 0", p5_bubbles);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
`ifdef PIPE_STAGE_PERF_EN
    perf_clr = 1'b0;
    p5_clr   = 1'b0;
    p5_stall = 6'b000000;
    p5_valid = 1'b0;
    p5_wd    = 5'd0;
    p5_wreg  = 1'b0;
    p5_wdata = 32'h0;
`endif
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_invalid_mask();
    test_back_to_back();
    test_reset_mid_hold();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
